// File: rtl/grad_mag_ori_3x3.sv
// grad_mag_ori_3x3: 3x3 window gradient magnitude and 8-bin orientation, 3-stage pipeline.
// Ports:
//   clk, rst (async, active-low)
//   win1..win9  : 3x3 window, rows top (oldest line) to bottom, columns left to right
//   start_flag  : one new window per cycle while high
//   mag, ori    : |dx|+|dy| and 45-degree orientation bin
//   row, col    : centre pixel coordinates
//   dout_valid  : outputs valid this cycle
//   frame_done  : pulse with the last output of a complete frame
module grad_mag_ori_3x3 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    win1,
  input  logic [7:0]    win2,
  input  logic [7:0]    win3,
  input  logic [7:0]    win4,
  input  logic [7:0]    win5,
  input  logic [7:0]    win6,
  input  logic [7:0]    win7,
  input  logic [7:0]    win8,
  input  logic [7:0]    win9,
  input  logic          start_flag,
  output logic [8:0]    mag,
  output logic [2:0]    ori,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          dout_valid,
  output logic          frame_done
);
  // corner and centre pixels do not enter the gradient
  logic unused_win;
  assign unused_win = ^{win1, win3, win5, win7, win9};
  logic start_prev_q;
  logic [CW-1:0] cnt_row_q, cnt_row_d, cnt_col_q, cnt_col_d, cur_row, cur_col;
  logic done_q, done_d, usable, last;
  logic [8:0] dx1_q, dx1_d, dy1_q, dy1_d;
  logic v1_q, fd1_q;
  logic [CW-1:0] row1_q, row1_d, col1_q, col1_d;
  logic [8:0] ndx, ndy;
  logic [7:0] adx2_q, adx2_d, ady2_q, ady2_d;
  logic sx2_q, sy2_q, v2_q, fd2_q;
  logic [CW-1:0] row2_q, col2_q;
  logic [8:0] mag_q, mag_d, mag_sum;
  logic [2:0] ori_q, ori_d, ori_n;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic dout_valid_q, frame_done_q;
  always_comb begin
    // a start_flag rise restarts the scan at the first full window (2,2)
    cur_row   = start_prev_q ? cnt_row_q : CW'(2);
    cur_col   = start_prev_q ? cnt_col_q : CW'(2);
    usable    = start_flag && cur_col >= CW'(2) && !done_q;
    last      = usable && cur_row == CW'(IMG_H-1) && cur_col == CW'(IMG_W-1);
    cnt_col_d = cur_col == CW'(IMG_W-1) ? '0 : cur_col + 1'b1;
    cnt_row_d = cur_row + CW'(cur_col == CW'(IMG_W-1));
    done_d    = start_flag && (done_q || last);
    dx1_d     = {1'b0, win6} - {1'b0, win4};
    dy1_d     = {1'b0, win2} - {1'b0, win8};
    row1_d    = cur_row - 1'b1;
    col1_d    = cur_col - 1'b1;
    ndx       = 9'd0 - dx1_q;
    ndy       = 9'd0 - dy1_q;
    // |-255..255| always fits in 8 bits
    adx2_d    = dx1_q[8] ? ndx[7:0] : dx1_q[7:0];
    ady2_d    = dy1_q[8] ? ndy[7:0] : dy1_q[7:0];
    mag_sum   = {1'b0, adx2_q} + {1'b0, ady2_q};
    ori_n     = mag_sum == 9'd0      ? 3'd0 :
                !sx2_q && !sy2_q     ? (ady2_q < adx2_q ? 3'd0 : 3'd1) :
                 sx2_q && !sy2_q     ? (ady2_q > adx2_q ? 3'd2 : 3'd3) :
                 sx2_q &&  sy2_q     ? (ady2_q < adx2_q ? 3'd4 : 3'd5) :
                                       (ady2_q > adx2_q ? 3'd6 : 3'd7);
    mag_d     = v2_q ? mag_sum : mag_q;
    ori_d     = v2_q ? ori_n : ori_q;
    row_d     = v2_q ? row2_q : row_q;
    col_d     = v2_q ? col2_q : col_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_prev_q <= 1'b0;
      cnt_row_q    <= '0;
      cnt_col_q    <= '0;
      done_q       <= 1'b0;
      dx1_q        <= '0;
      dy1_q        <= '0;
      v1_q         <= 1'b0;
      fd1_q        <= 1'b0;
      row1_q       <= '0;
      col1_q       <= '0;
      adx2_q       <= '0;
      ady2_q       <= '0;
      sx2_q        <= 1'b0;
      sy2_q        <= 1'b0;
      v2_q         <= 1'b0;
      fd2_q        <= 1'b0;
      row2_q       <= '0;
      col2_q       <= '0;
      mag_q        <= '0;
      ori_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_prev_q <= start_flag;
      cnt_row_q    <= cnt_row_d;
      cnt_col_q    <= cnt_col_d;
      done_q       <= done_d;
      dx1_q        <= dx1_d;
      dy1_q        <= dy1_d;
      v1_q         <= usable;
      fd1_q        <= last;
      row1_q       <= row1_d;
      col1_q       <= col1_d;
      adx2_q       <= adx2_d;
      ady2_q       <= ady2_d;
      sx2_q        <= dx1_q[8];
      sy2_q        <= dy1_q[8];
      v2_q         <= v1_q;
      fd2_q        <= fd1_q;
      row2_q       <= row1_q;
      col2_q       <= col1_q;
      mag_q        <= mag_d;
      ori_q        <= ori_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dout_valid_q <= v2_q;
      frame_done_q <= fd2_q;
    end
  end
  assign mag        = mag_q;
  assign ori        = ori_q;
  assign row        = row_q;
  assign col        = col_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_grad_mag_ori_3x3.sv
// tb_grad_mag_ori_3x3: directed self-checking bench for grad_mag_ori_3x3.
module tb_grad_mag_ori_3x3;
  logic clk = 1'b0;
  logic rst, start_flag;
  logic [7:0] w [1:9];
  logic [8:0] mag;
  logic [2:0] ori;
  logic [7:0] row, col;
  logic dout_valid, frame_done;
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic mon_clr = 1'b0;
  int nv, bad, nfd, er, ec, fr, fc, lr, lc, fdr, fdc;
  int t4 [12] = '{10, 50, 50, 77, 0, 40, 0, 0, 10, 0, 0, 255};
  int t6 [12] = '{50, 10, 10, 77, 0, 10, 20, 5, 0, 30, 255, 0};
  int t2 [12] = '{20, 200, 0, 77, 5, 10, 0, 20, 10, 0, 255, 0};
  int t8 [12] = '{20, 0, 200, 77, 5, 20, 20, 0, 0, 60, 0, 255};
  int em [12] = '{40, 240, 240, 0, 0, 40, 40, 25, 20, 90, 510, 510};
  int eo [12] = '{0, 2, 5, 0, 0, 4, 7, 1, 3, 6, 1, 5};
  always #5 clk = ~clk;
  grad_mag_ori_3x3 dut (
    .clk(clk), .rst(rst),
    .win1(w[1]), .win2(w[2]), .win3(w[3]), .win4(w[4]), .win5(w[5]),
    .win6(w[6]), .win7(w[7]), .win8(w[8]), .win9(w[9]),
    .start_flag(start_flag), .mag(mag), .ori(ori), .row(row), .col(col),
    .dout_valid(dout_valid), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // pixel(r,c) = 10*r + c, so every window has dx=2, dy=-20: mag 22, ori 6
  task automatic set_ramp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[1 + 3*r + c] = 8'(10*r + c);
  endtask
  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask
  // tracks the expected raster of centre coordinates for the ramp runs
  always @(negedge clk) begin
    if (mon_clr) begin
      nv = 0; bad = 0; nfd = 0; er = 1; ec = 1;
      fr = 0; fc = 0; lr = 0; lc = 0; fdr = 0; fdc = 0;
    end else if (mon_en && dout_valid) begin
      if (nv == 0) begin fr = int'(row); fc = int'(col); end
      nv++;
      if (int'(row) != er || int'(col) != ec || mag != 9'd22 || ori != 3'd6) bad++;
      lr = int'(row);
      lc = int'(col);
      if (frame_done) begin nfd++; fdr = int'(row); fdc = int'(col); end
      if (ec == 254) begin ec = 1; er++; end else ec++;
    end
  end
  initial begin
    rst = 1'b0;
    start_flag = 1'b0;
    for (int i = 1; i <= 9; i++) w[i] = 8'd0;
    #12;
    check("rst_mag", 32'(mag), 0);
    check("rst_ori", 32'(ori), 0);
    check("rst_row", 32'(row), 0);
    check("rst_col", 32'(col), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_fdone", 32'(frame_done), 0);
    step();
    rst = 1'b1;
    step();
    // directed vectors, one per cycle from position (2,2)
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        for (int j = 1; j <= 9; j++) w[j] = 8'd77;
        w[4] = 8'(t4[i]); w[6] = 8'(t6[i]); w[2] = 8'(t2[i]); w[8] = 8'(t8[i]);
        start_flag = 1'b1;
      end else start_flag = 1'b0;
      step();
      if (i < 2) check("vec_latency", 32'(dout_valid), 0);
      else begin
        check($sformatf("vec%0d_valid", i-2), 32'(dout_valid), 1);
        check($sformatf("vec%0d_mag", i-2), 32'(mag), 32'(em[i-2]));
        check($sformatf("vec%0d_ori", i-2), 32'(ori), 32'(eo[i-2]));
        check($sformatf("vec%0d_row", i-2), 32'(row), 1);
        check($sformatf("vec%0d_col", i-2), 32'(col), 32'(i-1));
        check($sformatf("vec%0d_fdone", i-2), 32'(frame_done), 0);
      end
    end
    step();
    check("hold_valid", 32'(dout_valid), 0);
    check("hold_mag", 32'(mag), 510);
    check("hold_ori", 32'(ori), 5);
    check("hold_col", 32'(col), 12);
    repeat (3) step();
    // full frame, start held past the final window
    set_ramp();
    mon_en = 1'b1;
    clear_mon();
    start_flag = 1'b1;
    repeat (65030) step();
    start_flag = 1'b0;
    repeat (4) step();
    check("frame_count", 32'(nv), 64516);
    check("frame_bad", 32'(bad), 0);
    check("frame_first_row", 32'(fr), 1);
    check("frame_first_col", 32'(fc), 1);
    check("frame_last_row", 32'(lr), 254);
    check("frame_last_col", 32'(lc), 254);
    check("frame_done_cnt", 32'(nfd), 1);
    check("frame_done_row", 32'(fdr), 254);
    check("frame_done_col", 32'(fdc), 254);
    // start dropped mid-frame after 300 windows
    clear_mon();
    start_flag = 1'b1;
    repeat (300) step();
    start_flag = 1'b0;
    repeat (10) step();
    check("drop_count", 32'(nv), 298);
    check("drop_bad", 32'(bad), 0);
    check("drop_fdone", 32'(nfd), 0);
    clear_mon();
    start_flag = 1'b1;
    repeat (5) step();
    start_flag = 1'b0;
    repeat (4) step();
    check("restart_row", 32'(fr), 1);
    check("restart_col", 32'(fc), 1);
    check("restart_count", 32'(nv), 5);
    check("restart_bad", 32'(bad), 0);
    // asynchronous reset mid-frame
    clear_mon();
    start_flag = 1'b1;
    repeat (20) step();
    check("pre_rst_valid", 32'(dout_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_mag", 32'(mag), 0);
    check("arst_ori", 32'(ori), 0);
    check("arst_row", 32'(row), 0);
    check("arst_col", 32'(col), 0);
    check("arst_valid", 32'(dout_valid), 0);
    check("arst_fdone", 32'(frame_done), 0);
    step();
    check("arst_hold_valid", 32'(dout_valid), 0);
    rst = 1'b1;
    clear_mon();
    repeat (8) step();
    start_flag = 1'b0;
    repeat (4) step();
    check("post_rst_row", 32'(fr), 1);
    check("post_rst_col", 32'(fc), 1);
    check("post_rst_count", 32'(nv), 9);
    check("post_rst_bad", 32'(bad), 0);
    check("post_rst_fdone", 32'(nfd), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
